dram_loader: RTL and testbench

DRAM_LOADER -- requirements
Module: dram_loader

---
 rtl/dram_loader.sv | 166 ++++++++++++++++
 tb/tb_dram_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dram_loader.sv
// Streams upstream bytes into consecutive DRAM addresses starting at a captured base.
// Optional running byte checksum output enabled with DRAM_LOADER_CHECKSUM_EN.
module dram_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done,
`ifdef DRAM_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [ADDR_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic [ADDR_W-1:0] len_q,   len_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              wren_q,  wren_d;
  logic              done_q,  done_d;
  logic              accept;
  logic              start_ok;
  logic              last_beat;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (accept && last_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    start_ok  = 1'b0;
    case (state_q)
      IDLE:    start_ok = start;
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: ;
    endcase
    accept    = in_valid && in_ready;
    last_beat = (count_q + ADDR_W'(1)) == len_q;
  end

  // Datapath next values: write port, pointer and counters
  always_comb begin
    ptr_d   = ptr_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    done_d  = (state_q == DONE);
    if (start_ok) begin
      count_d = '0;
      if (length != '0) begin
        ptr_d = base_addr;
        len_d = length;
      end
    end
    if (accept) begin
      addr_d  = ptr_q;
      data_d  = in_data;
      wren_d  = 1'b1;
      ptr_d   = ptr_q + ADDR_W'(1);
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
    end
  end

  assign address = addr_q;
  assign data    = data_q;
  assign wren    = wren_q;
  assign done    = done_q;
  assign count   = count_q;

`ifdef DRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Mod-2^DATA_W sum of accepted bytes, restarted by each accepted start
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end
    if (accept) begin
      csum_d = csum_q + in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_dram_loader.sv
// Directed and randomized bench for dram_loader against a queue/array reference model.
// Define DRAM_LOADER_CHECKSUM_EN to also exercise the checksum output.
module tb_dram_loader;

  logic        clock = 1'b0;
  logic        reset, start, in_valid;
  logic [15:0] base_addr, length, address, count;
  logic [7:0]  in_data, data;
  logic        in_ready, wren, busy, done;
`ifdef DRAM_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  dram_loader #(.ADDR_W(16), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .address(address), .data(data), .wren(wren),
    .busy(busy), .done(done),
`ifdef DRAM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .count(count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int nwren = 0;
  int ndone = 0;
  logic [7:0]  mem [0:65535];
  logic [23:0] wq[$];
  logic [7:0]  src_q[$];

  // DRAM side: writes land on the falling edge
  always @(negedge clock) begin
    if (wren === 1'b1) begin
      mem[address] = data;
      wq.push_back({address, data});
      nwren++;
    end
    if (done === 1'b1) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete load of src_q[0..n-1]; gap<0 selects random stall lengths
  task automatic do_load(input string tag, input logic [15:0] b, input logic [15:0] n, input int gap);
    int nw0, nd0, g;
    logic [7:0]  sum;
    logic [15:0] ea;
    logic [23:0] w;
    nw0 = nwren; nd0 = ndone; sum = 8'h00;
    wq.delete();
    base_addr = b; length = n; start = 1'b1;
    step();
    start = 1'b0; base_addr = 16'($urandom); length = 16'($urandom);
    chk({tag, "_count0"}, 32'(count), 32'd0);
`ifdef DRAM_LOADER_CHECKSUM_EN
    chk({tag, "_csum0"}, 32'(checksum), 32'd0);
`endif
    if (n == 16'd0) begin
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      chk({tag, "_ready0"}, 32'(in_ready), 32'd0);
      step();
      chk({tag, "_done"}, 32'(done), 32'd1);
      step();
      chk({tag, "_done_once"}, 32'(done), 32'd0);
      chk({tag, "_nowren"}, 32'(nwren - nw0), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      return;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < int'(n); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0; in_data = 8'($urandom);
        start = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        chk({tag, "_gap_wren"}, 32'(wren), 32'd0);
        chk({tag, "_gap_count"}, 32'(count), 32'(i));
        if (i > 0) chk({tag, "_gap_addr"}, 32'(address), 32'(16'(b + 16'(i - 1))));
      end
      in_valid = 1'b1; in_data = src_q[i];
      step();
      in_valid = 1'b0;
      ea = 16'(b + 16'(i));
      sum = sum + src_q[i];
      chk({tag, "_wren"}, 32'(wren), 32'd1);
      chk({tag, "_addr"}, 32'(address), 32'(ea));
      chk({tag, "_data"}, 32'(data), 32'(src_q[i]));
      chk({tag, "_count"}, 32'(count), 32'(i + 1));
    end
    chk({tag, "_ready_end"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    // start during DONE must be ignored
    start = 1'b1; base_addr = 16'h5555; length = 16'd7;
    step();
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_wren_after"}, 32'(wren), 32'd0);
    step();
    chk({tag, "_done_once"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_final_count"}, 32'(count), 32'(n));
    chk({tag, "_nwren"}, 32'(nwren - nw0), 32'(n));
    chk({tag, "_ndone"}, 32'(ndone - nd0), 32'd1);
`ifdef DRAM_LOADER_CHECKSUM_EN
    chk({tag, "_csum"}, 32'(checksum), 32'(sum));
`endif
    for (int i = 0; i < int'(n); i++) begin
      ea = 16'(b + 16'(i));
      w = (wq.size() != 0) ? wq.pop_front() : 24'hxxxxxx;
      chk({tag, "_wq"}, 32'(w), 32'({ea, src_q[i]}));
      chk({tag, "_mem"}, 32'(mem[ea]), 32'(src_q[i]));
    end
  endtask

  initial begin
    int nw0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    base_addr = 16'h1234; length = 16'd3;
    step(); step();
    start = 1'b1;
    step();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();
    chk("idle_ready", 32'(in_ready), 32'd0);

    src_q = '{8'hA1, 8'hA1, 8'h9D, 8'hA1};
    do_load("b2b", 16'h0000, 16'd4, 0);

    src_q = '{8'h11, 8'h22, 8'h33};
    do_load("gaps", 16'h0010, 16'd3, 2);

    src_q = '{8'h5A, 8'hC3, 8'h0F};
    do_load("wrap", 16'hFFFE, 16'd3, 0);

    do_load("len0", 16'h4000, 16'd0, 0);

    // Abort mid-load with reset after two beats
    nw0 = nwren;
    base_addr = 16'h0020; length = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      step();
    end
    reset = 1'b1; start = 1'b1;
    step();
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wren", 32'(wren), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    chk("abort_nwren", 32'(nwren - nw0), 32'd2);
    chk("abort_idle", 32'(in_ready), 32'd0);
    src_q = '{8'h77, 8'h88};
    do_load("after_abort", 16'h0030, 16'd2, 0);

    src_q = '{8'hFF, 8'h02};
    do_load("csum", 16'h0100, 16'd2, 1);

    for (int r = 0; r < 4; r++) begin
      logic [15:0] n;
      n = 16'($urandom_range(1, 8));
      src_q.delete();
      for (int i = 0; i < int'(n); i++) src_q.push_back(8'($urandom));
      do_load($sformatf("rnd%0d", r), 16'($urandom), n, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
